// File: rtl/spi_word_arbiter.sv
// Round-robin arbiter/sequencer sharing one SPI master between NREQ word
// requesters: latches the winner's word, pulses Start, waits for Done,
// acknowledges the winner, inserts an idle gap and watches for a stuck master.
module spi_word_arbiter #(
  parameter int NREQ    = 4,
  parameter int BITS    = 32,
  parameter int GAP     = 2,
  parameter int TIMEOUT = 64
) (
  input  logic               Clock,
  input  logic               Reset_n,
  input  logic [NREQ-1:0]    Req,
  input  logic [NREQ*BITS-1:0] ReqData,
  output logic [NREQ-1:0]    Ack,
  output logic [NREQ-1:0]    Grant,
  output logic               Busy,
  output logic               Timeout,
  output logic               SpiStart,
  output logic [BITS-1:0]    SpiData,
  input  logic               SpiDone,
  input  logic               SpiIdle
);

  localparam int PW   = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int WD_W = $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_LAST  = WD_W'(TIMEOUT - 1);
  localparam logic [7:0]      GAP_LAST = 8'(GAP - 1);
  localparam logic [PW-1:0]   PTR_LAST = PW'(NREQ - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2,
    ST_GAP   = 2'd3
  } state_t;

  state_t            state_r, state_s;
  logic [PW-1:0]     ptr_r, ptr_s;
  logic [PW-1:0]     win_r, win_s;
  logic [WD_W-1:0]   wd_r, wd_s;
  logic [7:0]        gap_r, gap_s;
  logic [NREQ-1:0]   ack_r, ack_s;
  logic [NREQ-1:0]   grant_r, grant_s;
  logic              busy_r, busy_s;
  logic              timeout_r, timeout_s;
  logic              start_r, start_s;
  logic [BITS-1:0]   data_r, data_s;
  logic [NREQ-1:0]   eligible_s;
  logic              pick_valid_s;
  logic [PW-1:0]     pick_idx_s;

  // Index p+off folded back into 0..NREQ-1 (off is always below NREQ).
  function automatic logic [PW-1:0] wrap_idx(input logic [PW-1:0] p, input int off);
    int s;
    s = int'(p) + off;
    return (s >= NREQ) ? PW'(s - NREQ) : PW'(s);
  endfunction

  // Round-robin successor of a requester index.
  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] w);
    return (w == PTR_LAST) ? {PW{1'b0}} : w + PW'(1);
  endfunction

  // Pick the first eligible requester scanning upward from the pointer;
  // the requester currently being acknowledged is masked out.
  always_comb begin
    eligible_s   = Req & ~ack_r;
    pick_valid_s = 1'b0;
    pick_idx_s   = ptr_r;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (eligible_s[wrap_idx(ptr_r, i)]) begin
        pick_valid_s = 1'b1;
        pick_idx_s   = wrap_idx(ptr_r, i);
      end else begin
        pick_idx_s   = pick_idx_s;
      end
    end
  end

  // Next-state and next-output logic for the IDLE/START/WAIT/GAP sequencer.
  always_comb begin
    state_s   = state_r;
    ptr_s     = ptr_r;
    win_s     = win_r;
    wd_s      = wd_r;
    gap_s     = gap_r;
    ack_s     = {NREQ{1'b0}};
    grant_s   = grant_r;
    timeout_s = timeout_r;
    start_s   = 1'b0;
    data_s    = data_r;
    case (state_r)
      ST_IDLE: begin
        if (pick_valid_s && SpiIdle) begin
          data_s              = ReqData[pick_idx_s*BITS +: BITS];
          grant_s             = {NREQ{1'b0}};
          grant_s[pick_idx_s] = 1'b1;
          win_s               = pick_idx_s;
          start_s             = 1'b1;
          state_s             = ST_START;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_START: begin
        wd_s    = {WD_W{1'b0}};
        state_s = ST_WAIT;
      end
      ST_WAIT: begin
        wd_s = wd_r + WD_W'(1);
        if (SpiDone || (wd_r == WD_LAST)) begin
          // Done takes priority over a coincident watchdog expiry.
          if (SpiDone) begin
            ack_s[win_r] = 1'b1;
          end else begin
            timeout_s = 1'b1;
          end
          grant_s = {NREQ{1'b0}};
          ptr_s   = next_ptr(win_r);
          gap_s   = 8'd0;
          state_s = (GAP == 0) ? ST_IDLE : ST_GAP;
        end else begin
          state_s = ST_WAIT;
        end
      end
      ST_GAP: begin
        if (gap_r == GAP_LAST) begin
          state_s = ST_IDLE;
        end else begin
          gap_s = gap_r + 8'd1;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
    busy_s = (state_s != ST_IDLE);
  end

  // State and registered-output update; everything clears on async reset.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state_r   <= ST_IDLE;
      ptr_r     <= {PW{1'b0}};
      win_r     <= {PW{1'b0}};
      wd_r      <= {WD_W{1'b0}};
      gap_r     <= 8'd0;
      ack_r     <= {NREQ{1'b0}};
      grant_r   <= {NREQ{1'b0}};
      busy_r    <= 1'b0;
      timeout_r <= 1'b0;
      start_r   <= 1'b0;
      data_r    <= {BITS{1'b0}};
    end else begin
      state_r   <= state_s;
      ptr_r     <= ptr_s;
      win_r     <= win_s;
      wd_r      <= wd_s;
      gap_r     <= gap_s;
      ack_r     <= ack_s;
      grant_r   <= grant_s;
      busy_r    <= busy_s;
      timeout_r <= timeout_s;
      start_r   <= start_s;
      data_r    <= data_s;
    end
  end

  assign Ack      = ack_r;
  assign Grant    = grant_r;
  assign Busy     = busy_r;
  assign Timeout  = timeout_r;
  assign SpiStart = start_r;
  assign SpiData  = data_r;

endmodule
